// File: rtl/secure_reg_bank.sv
// Key-protected register bank: unlock by key, idle relock, one-per-cycle zeroize sweep,
// and a permanent lockout after repeated wrong keys.
module secure_reg_bank #(
  parameter int               DATA_W     = 32,
  parameter int               NUM_REGS   = 4,
  parameter int               KEY_W      = 32,
  parameter logic [KEY_W-1:0] UNLOCK_KEY = 'hA5A5_5A5A,
  parameter int               MAX_FAIL   = 3,
  parameter int               TIMEOUT    = 16,
  localparam int              AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_err_o,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              unlock_valid_i,
  input  logic [KEY_W-1:0]  unlock_key_i,
  input  logic              zeroize_req_i,
  output logic              locked_o,
  output logic              zeroize_busy_o,
  output logic              lockout_o
);

  localparam int TW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam int FW = (MAX_FAIL > 0) ? (($clog2(MAX_FAIL + 1) > 0) ? $clog2(MAX_FAIL + 1) : 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [AW-1:0] Z_LAST   = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_ZEROIZE, S_LOCKOUT} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     fail_q, fail_d, fail_inc;
  logic [TW-1:0]     idle_q, idle_d;
  logic [AW-1:0]     zidx_q, zidx_d;
  logic              bound_q, bound_d;
  logic              wr_err_q, wr_ready_q, locked_q, zbusy_q, lockout_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              accept, wr_err_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // zeroize_req pre-empts a same-cycle write, so it must also gate acceptance
  assign accept   = wr_valid_i && (state_q == S_UNLOCKED) && in_range(wr_addr_i) && !zeroize_req_i;
  assign wr_err_d = wr_valid_i && !accept;
  assign fail_inc = (fail_q >= FAIL_MAX) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    idle_d  = idle_q;
    zidx_d  = zidx_q;
    bound_d = bound_q;
    case (state_q)
      S_LOCKED: begin
        if (zeroize_req_i) begin
          state_d = S_ZEROIZE;
          zidx_d  = '0;
          bound_d = 1'b0;
        end else if (unlock_valid_i) begin
          if (unlock_key_i == UNLOCK_KEY) begin
            state_d = S_UNLOCKED;
            fail_d  = '0;
            idle_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc >= FAIL_MAX) begin
              state_d = S_ZEROIZE;
              zidx_d  = '0;
              bound_d = 1'b1;
            end
          end
        end
      end
      S_UNLOCKED: begin
        if (zeroize_req_i) begin
          state_d = S_ZEROIZE;
          zidx_d  = '0;
          bound_d = 1'b0;
        end else if (accept) begin
          idle_d = '0;
        end else if (idle_q >= TO_LAST) begin
          state_d = S_LOCKED;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_ZEROIZE: begin
        if (zidx_q >= Z_LAST) begin
          state_d = bound_q ? S_LOCKOUT : S_LOCKED;
          zidx_d  = '0;
          if (!bound_q) fail_d = '0;
        end else begin
          zidx_d = zidx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_LOCKED;
      fail_q     <= '0;
      idle_q     <= '0;
      zidx_q     <= '0;
      bound_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      locked_q   <= 1'b1;
      zbusy_q    <= 1'b0;
      lockout_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      idle_q     <= idle_d;
      zidx_q     <= zidx_d;
      bound_q    <= bound_d;
      wr_err_q   <= wr_err_d;
      wr_ready_q <= (state_d == S_UNLOCKED);
      locked_q   <= (state_d != S_UNLOCKED);
      zbusy_q    <= (state_d == S_ZEROIZE);
      lockout_q  <= (state_d == S_LOCKOUT);
      rd_data_q  <= ((state_q == S_UNLOCKED) && in_range(rd_addr_i)) ? regs_q[rd_addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (accept) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end else if (state_q == S_ZEROIZE) begin
      regs_q[zidx_q] <= '0;
    end
  end

  assign wr_ready_o     = wr_ready_q;
  assign wr_err_o       = wr_err_q;
  assign rd_data_o      = rd_data_q;
  assign locked_o       = locked_q;
  assign zeroize_busy_o = zbusy_q;
  assign lockout_o      = lockout_q;

endmodule

// File: tb/tb_secure_reg_bank.sv
// Scoreboarded random + directed bench for secure_reg_bank against a cycle-level
// behavioural model of the bank's access rules.
module tb_secure_reg_bank;
  localparam int          N    = 4;
  localparam logic [31:0] KEY  = 32'hA5A5_5A5A;
  localparam int          MAXF = 3;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, wr_err, unlock_valid, zeroize_req;
  logic        locked, zeroize_busy, lockout;
  logic [1:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data, unlock_key;

  secure_reg_bank dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_err_o(wr_err), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .unlock_valid_i(unlock_valid), .unlock_key_i(unlock_key), .zeroize_req_i(zeroize_req),
    .locked_o(locked), .zeroize_busy_o(zeroize_busy), .lockout_o(lockout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        werr;
    logic [31:0] rd;
    logic        rdy, lk, zb, lo;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // behavioural model: mode 0=locked 1=open 2=sweeping 3=dead
  logic [31:0] m_regs [N];
  int          m_mode, m_fails, m_idle, m_sweep;
  bit          m_dead_after;

  function automatic obs_t cur_obs();
    return '{werr: wr_err, rd: rd_data, rdy: wr_ready, lk: locked, zb: zeroize_busy, lo: lockout};
  endfunction

  function automatic obs_t reset_obs();
    return '{werr: 1'b0, rd: 32'h0, rdy: 1'b0, lk: 1'b1, zb: 1'b0, lo: 1'b0};
  endfunction

  function automatic void check(input string name, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got werr=%b rd=%h rdy=%b lk=%b zb=%b lo=%b, want werr=%b rd=%h rdy=%b lk=%b zb=%b lo=%b",
               name, got.werr, got.rd, got.rdy, got.lk, got.zb, got.lo,
               want.werr, want.rd, want.rdy, want.lk, want.zb, want.lo);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 32'h0;
    m_mode = 0; m_fails = 0; m_idle = 0; m_sweep = 0; m_dead_after = 0;
  endfunction

  function automatic obs_t model_step(input bit wv, input int wa, input logic [31:0] wd,
                                      input int ra, input bit uv, input logic [31:0] key, input bit zr);
    obs_t e;
    bit   take;
    e.rd   = (m_mode == 1 && ra < N) ? m_regs[ra] : 32'h0;
    take   = (m_mode == 1) && wv && (wa < N) && !zr;
    e.werr = wv && !take;
    if (m_mode == 0) begin
      if (zr) begin m_mode = 2; m_sweep = 0; m_dead_after = 0; end
      else if (uv && key == KEY) begin m_mode = 1; m_fails = 0; m_idle = 0; end
      else if (uv) begin
        if (m_fails < MAXF) m_fails++;
        if (m_fails >= MAXF) begin m_mode = 2; m_sweep = 0; m_dead_after = 1; end
      end
    end else if (m_mode == 1) begin
      if (zr) begin m_mode = 2; m_sweep = 0; m_dead_after = 0; end
      else if (take) begin m_regs[wa] = wd; m_idle = 0; end
      else begin
        m_idle++;
        if (m_idle >= TO) begin m_mode = 0; m_idle = 0; end
      end
    end else if (m_mode == 2) begin
      m_regs[m_sweep] = 32'h0;
      m_sweep++;
      if (m_sweep == N) begin
        m_mode = m_dead_after ? 3 : 0;
        if (!m_dead_after) m_fails = 0;
      end
    end
    e.rdy = (m_mode == 1);
    e.lk  = (m_mode != 1);
    e.zb  = (m_mode == 2);
    e.lo  = (m_mode == 3);
    return e;
  endfunction

  task automatic step(input bit wv, input int wa, input logic [31:0] wd,
                      input int ra, input bit uv, input logic [31:0] key, input bit zr);
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = wv; wr_addr = 2'(wa); wr_data = wd; rd_addr = 2'(ra);
    unlock_valid = uv; unlock_key = key; zeroize_req = zr;
    sb.push_back(model_step(wv, wa, wd, ra, uv, key, zr));
  endtask

  task automatic idle(input int n, input int ra);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, ra, 0, 32'h0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      wr_valid = 0; unlock_valid = 0; zeroize_req = 0;
      model_reset();
      sb.push_back(reset_obs());
    end
  endtask

  // monitor: one expected observation per clock after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check("cycle", cur_obs(), sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; wr_valid = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    unlock_valid = 0; unlock_key = 0; zeroize_req = 0;
    model_reset();
    do_reset(3);

    // write while locked is rejected
    step(1, 1, 32'h1234, 1, 0, 0, 0);
    idle(2, 1);

    // unlock, write, read back
    step(0, 0, 0, 0, 1, KEY, 0);
    step(1, 2, 32'hDEAD_BEEF, 2, 0, 0, 0);
    idle(2, 2);

    // idle relock keeps contents
    step(1, 0, 32'h0BAD_F00D, 0, 0, 0, 0);
    idle(TO + 2, 0);
    step(0, 0, 0, 0, 1, KEY, 0);
    idle(2, 0);

    // zeroize with a same-cycle write
    step(1, 3, 32'hFFFF_FFFF, 2, 0, 0, 1);
    idle(N + 2, 2);
    step(0, 0, 0, 0, 1, KEY, 0);
    for (int r = 0; r < N; r++) step(0, 0, 0, r, 0, 0, 0);
    idle(1, 0);

    // three wrong keys -> sweep -> lockout; correct key then ignored
    do_reset(2);
    for (int i = 0; i < MAXF; i++) step(0, 0, 0, 0, 1, 32'h0, 0);
    idle(N + 2, 0);
    step(0, 0, 0, 0, 1, KEY, 0);
    step(1, 1, 32'h77, 1, 0, 0, 1);
    idle(3, 1);

    // async reset two cycles into a sweep
    do_reset(2);
    step(0, 0, 0, 0, 1, KEY, 0);
    for (int r = 0; r < N; r++) step(1, r, 32'h1111_0000 + r, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    wr_valid = 0; unlock_valid = 0; zeroize_req = 0;
    #1 check("async_reset", cur_obs(), reset_obs());
    model_reset();
    sb.push_back(reset_obs());
    do_reset(1);
    step(0, 0, 0, 0, 1, KEY, 0);
    for (int r = 0; r < N; r++) step(0, 0, 0, r, 0, 0, 0);
    idle(1, 0);

    // randomized segments; sparse-write segments exercise idle relock
    for (int seg = 0; seg < 6; seg++) begin
      int wprob;
      wprob = (seg % 2) ? 2 : 30;
      do_reset(2);
      for (int c = 0; c < 250; c++) begin
        bit          wv, uv, zr;
        logic [31:0] k;
        wv = ($urandom_range(0, 63) < wprob);
        uv = ($urandom_range(0, 15) == 0);
        zr = ($urandom_range(0, 63) == 0);
        k  = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
        step(wv, $urandom_range(0, N - 1), $urandom, $urandom_range(0, N - 1), uv, k, zr);
      end
    end

    idle(2, 0);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending observations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/secure_reg_bank.md
SECURE_REG_BANK -- requirements
Module: secure_reg_bank

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of the data buses.
REQ-002 Parameter NUM_REGS, default 4, number of registers; AW = max(1, clog2(NUM_REGS)).
REQ-003 Parameter KEY_W, default 32, width of the unlock key.
REQ-004 Parameter UNLOCK_KEY, default 32'hA5A5_5A5A (KEY_W bits), key that unlocks the bank.
REQ-005 Parameter MAX_FAIL, default 3, wrong-key attempts that trigger zeroize plus permanent lockout.
REQ-006 Parameter TIMEOUT, default 16, idle UNLOCKED cycles before automatic relock.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 wr_valid  in  1  write request.
REQ-010 wr_ready  out  1  write accept; high only in UNLOCKED.
REQ-011 wr_addr  in  AW  write register index.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 wr_err  out  1  one-cycle pulse on rejected write.
REQ-014 rd_addr  in  AW  read register index.
REQ-015 rd_data  out  DATA_W  registered read data, masked to 0 unless UNLOCKED.
REQ-016 unlock_valid  in  1  unlock attempt strobe.
REQ-017 unlock_key  in  KEY_W  presented key.
REQ-018 zeroize_req  in  1  request to clear all registers.
REQ-019 locked  out  1  high in every state except UNLOCKED.
REQ-020 zeroize_busy  out  1  high while in ZEROIZE.
REQ-021 lockout  out  1  high in LOCKOUT.

Function
REQ-022 FSM states LOCKED, UNLOCKED, ZEROIZE, LOCKOUT; state after reset is LOCKED.
REQ-023 LOCKED: unlock_valid with unlock_key==UNLOCK_KEY -> UNLOCKED next cycle, fail counter cleared, idle timer cleared.
REQ-024 LOCKED: unlock_valid with wrong key -> fail counter +1; when count reaches MAX_FAIL -> ZEROIZE, then LOCKOUT on completion instead of LOCKED.
REQ-025 UNLOCKED: idle timer +1 each cycle without an accepted write; accepted write clears it; timer reaching TIMEOUT-1 with no accepted write that cycle -> LOCKED next cycle.
REQ-026 UNLOCKED: unlock_valid ignored (no counter or timer effect).
REQ-027 Write accepted on wr_valid && wr_ready && wr_addr<NUM_REGS; reg[wr_addr] updated at that edge.
REQ-028 wr_valid while wr_ready low, or wr_addr>=NUM_REGS -> no register change, wr_err high the following cycle for exactly one cycle per rejected request cycle.
REQ-029 rd_data latency 1 cycle: rd_data <= reg[rd_addr] if state==UNLOCKED and rd_addr<NUM_REGS, else 0; read of register written same cycle returns old value.
REQ-030 zeroize_req in LOCKED or UNLOCKED -> ZEROIZE next cycle; ZEROIZE clears reg[0..NUM_REGS-1], one per cycle ascending, exactly NUM_REGS cycles, then LOCKED (or LOCKOUT per REQ-024); fail counter cleared unless bound for LOCKOUT.
REQ-031 ZEROIZE: writes rejected (REQ-028), unlock_valid ignored, further zeroize_req ignored (no restart).
REQ-032 LOCKOUT: terminal until rst_n; all writes rejected, unlock/zeroize ignored, rd_data 0.
REQ-033 Priority in one cycle: zeroize_req > unlock_valid > write acceptance > timeout; write accepted in UNLOCKED the same cycle as zeroize_req is not performed and flags wr_err.
REQ-034 Counters saturate; no wrap-around for any parameter value.

Reset
REQ-035 rst_n low, asynchronously: all registers 0, state LOCKED, fail counter 0, idle timer 0, zeroize index 0.
REQ-036 During reset: wr_ready 0, wr_err 0, rd_data 0, locked 1, zeroize_busy 0, lockout 0; reset mid-ZEROIZE aborts it with all registers already 0.

Verification (defaults)
REQ-037 Reset; write 0x1234 to reg 1 while LOCKED -> wr_err pulse, reg unchanged, rd_data 0.
REQ-038 Unlock with 0xA5A55A5A; write 0xDEADBEEF to reg 2; read reg 2 -> rd_data 0xDEADBEEF one cycle after rd_addr=2.
REQ-039 Unlock, write reg 0, then 16 idle cycles -> locked=1, rd_data of reg 0 reads 0; re-unlock -> original value returned.
REQ-040 Three wrong keys (0x0) -> zeroize_busy high 4 cycles, then lockout=1; correct key then has no effect.
REQ-041 Unlocked, zeroize_req and wr_valid same cycle -> wr_err pulse, 4-cycle sweep, all regs 0, locked=1.
REQ-042 Drop rst_n two cycles into ZEROIZE -> all outputs at reset values immediately, state LOCKED after release.
